mem_stage_sram_ctrl: RTL and testbench

MEM_STAGE_SRAM_CTRL -- requirements
Module: mem_stage_sram_ctrl

---
 rtl/mem_stage_sram_ctrl_pkg.sv | 17 +
 rtl/mem_stage_sram_ctrl.sv | 127 ++++++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared definitions for the MEM-stage SRAM controller: FSM states,
// parameter defaults and SRAM bus widths.
package mem_stage_sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int WAIT_CYCLES_DEF = 2;
  localparam int DATA_BASE_DEF   = 1024;
  localparam int SRAM_ADDR_W     = 18;
  localparam int SRAM_DATA_W     = 16;

endpackage

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage controller splitting each 32-bit load/store into two 16-bit
// SRAM accesses, holding the pipeline via ready while the access runs.
module mem_stage_sram_ctrl
  import mem_stage_sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter int DATA_BASE   = DATA_BASE_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_r_en,
  input  logic                   mem_w_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in,
  output logic                   sram_we_n
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(WAIT_CYCLES - 2);

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   op_wr_q;
  logic [16:0]            word_q;
  logic [31:0]            wdata_q;
  logic [SRAM_DATA_W-1:0] rd_lo_q;
  logic [31:0]            read_data_q;
  logic [SRAM_ADDR_W-1:0] sram_addr_q;
  logic [SRAM_DATA_W-1:0] sram_dq_out_q;
  logic                   sram_dq_oe_q;
  logic                   sram_we_n_q;

  logic                   req;
  logic [31:0]            offset_d;
  logic [16:0]            word_d;
  logic [2:0]             unused_offset_bits;

  assign req      = mem_r_en | mem_w_en;
  assign offset_d = address - 32'(DATA_BASE);
  assign word_d   = offset_d[18:2];
  assign unused_offset_bits = {^offset_d[31:19], offset_d[1:0]};

  // DONE always reports ready so the completing instruction is not re-issued
  assign ready = (state_q == DONE) || ((state_q == IDLE) && !req);

  assign read_data   = read_data_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = sram_dq_out_q;
  assign sram_dq_oe  = sram_dq_oe_q;
  assign sram_we_n   = sram_we_n_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      op_wr_q       <= 1'b0;
      word_q        <= '0;
      wdata_q       <= '0;
      rd_lo_q       <= '0;
      read_data_q   <= '0;
      sram_addr_q   <= '0;
      sram_dq_out_q <= '0;
      sram_dq_oe_q  <= 1'b0;
      sram_we_n_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            // a write wins when both enables are set
            state_q       <= LOW;
            cnt_q         <= '0;
            op_wr_q       <= mem_w_en;
            word_q        <= word_d;
            wdata_q       <= write_data;
            sram_addr_q   <= {word_d, 1'b0};
            sram_dq_out_q <= write_data[15:0];
            sram_dq_oe_q  <= mem_w_en;
            sram_we_n_q   <= ~mem_w_en;
          end
        end
        LOW: begin
          if (cnt_q == LAST) begin
            state_q       <= HIGH;
            cnt_q         <= '0;
            sram_addr_q   <= {word_q, 1'b1};
            sram_dq_out_q <= wdata_q[31:16];
            sram_dq_oe_q  <= op_wr_q;
            sram_we_n_q   <= ~op_wr_q;
            if (!op_wr_q) rd_lo_q <= sram_dq_in;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            // release the strobe for the final cycle so data is held past it
            if (cnt_q == PRE_LAST) sram_we_n_q <= 1'b1;
          end
        end
        HIGH: begin
          if (cnt_q == LAST) begin
            state_q      <= DONE;
            cnt_q        <= '0;
            sram_dq_oe_q <= 1'b0;
            sram_we_n_q  <= 1'b1;
            if (!op_wr_q) read_data_q <= {sram_dq_in, rd_lo_q};
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == PRE_LAST) sram_we_n_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl with a small behavioural SRAM
// and hand-computed expectations.
module tb_mem_stage_sram_ctrl;

  logic        clk;
  logic        rst;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;

  logic [15:0] sram_mem [16] = '{default: 16'h0000};
  int          wr_count = 0;
  wire  [13:0] unused_addr_hi = sram_addr[17:4];

  int total = 0;
  int bad   = 0;

  mem_stage_sram_ctrl #(.WAIT_CYCLES(2), .DATA_BASE(1024)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_r_en    (mem_r_en),
    .mem_w_en    (mem_w_en),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .ready       (ready),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_dq_in  (sram_dq_in),
    .sram_we_n   (sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous-read SRAM; a write lands on any edge with the strobe low
  assign sram_dq_in = sram_mem[sram_addr[3:0]];
  always @(posedge clk) begin
    if (!sram_we_n && sram_dq_oe) begin
      sram_mem[sram_addr[3:0]] <= sram_dq_out;
      wr_count <= wr_count + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drive a request from just after a falling edge and follow it to DONE
  task automatic access(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, output int lows, output int wel,
                        output int oeh);
    mem_r_en   = r;
    mem_w_en   = w;
    address    = a;
    write_data = d;
    lows = 0;
    wel  = 0;
    oeh  = 0;
    #1;
    for (int i = 0; i < 40 && !ready; i++) begin
      lows++;
      if (!sram_we_n) wel++;
      if (sram_dq_oe) oeh++;
      @(negedge clk);
      #1;
    end
    chk("access_completes", {31'd0, ready}, 32'd1);
  endtask

  initial begin
    int lows, wel, oeh, lows2, wel2, oeh2, wr_before;
    rst        = 1'b1;
    mem_r_en   = 1'b0;
    mem_w_en   = 1'b0;
    address    = 32'd0;
    write_data = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_ready",     {31'd0, ready},      32'd1);
    chk("rst_read_data", read_data,           32'd0);
    chk("rst_sram_addr", {14'd0, sram_addr},  32'd0);
    chk("rst_dq_out",    {16'd0, sram_dq_out}, 32'd0);
    chk("rst_dq_oe",     {31'd0, sram_dq_oe}, 32'd0);
    chk("rst_we_n",      {31'd0, sram_we_n},  32'd1);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ready_we_oe", {29'd0, ready, sram_we_n, sram_dq_oe}, 32'd6);
    end

    // Store 0xDEADBEEF at byte 1028 -> halfwords 2 and 3
    access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, lows, wel, oeh);
    chk("store_ready_low", lows, 32'd5);
    chk("store_we_low",    wel,  32'd2);
    chk("store_oe_high",   oeh,  32'd4);
    mem_w_en = 1'b0;
    chk("store_lo_half", {16'd0, sram_mem[2]}, 32'h0000BEEF);
    chk("store_hi_half", {16'd0, sram_mem[3]}, 32'h0000DEAD);
    chk("store_read_data_held", read_data, 32'd0);
    @(negedge clk);
    chk("store_idle_after", {31'd0, ready}, 32'd1);

    access(1'b1, 1'b0, 32'd1028, 32'd0, lows, wel, oeh);
    chk("load_ready_low", lows, 32'd5);
    chk("load_we_low",    wel,  32'd0);
    chk("load_oe_high",   oeh,  32'd0);
    chk("load_data",      read_data, 32'hDEADBEEF);
    mem_r_en = 1'b0;
    @(negedge clk);
    chk("load_data_held", read_data, 32'hDEADBEEF);

    // Reset while the high half of a load is in flight
    mem_r_en = 1'b1;
    address  = 32'd1028;
    repeat (3) @(negedge clk);
    chk("midhigh_stalled", {31'd0, ready}, 32'd0);
    wr_before = wr_count;
    rst      = 1'b1;
    mem_r_en = 1'b0;
    @(negedge clk);
    chk("midrst_ready",     {31'd0, ready},     32'd1);
    chk("midrst_read_data", read_data,          32'd0);
    chk("midrst_we_n",      {31'd0, sram_we_n}, 32'd1);
    chk("midrst_oe",        {31'd0, sram_dq_oe}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_idle_ready", {31'd0, ready}, 32'd1);
    chk("midrst_no_write",   wr_count, wr_before);

    access(1'b0, 1'b1, 32'd1024, 32'hCAFEF00D, lows, wel, oeh);
    mem_w_en = 1'b0;
    @(negedge clk);

    // Back-to-back load then store at 1024, no gap cycle allowed
    access(1'b1, 1'b0, 32'd1024, 32'd0, lows, wel, oeh);
    chk("b2b_load_data", read_data, 32'hCAFEF00D);
    mem_r_en   = 1'b0;
    mem_w_en   = 1'b1;
    write_data = 32'h0BADC0DE;
    @(negedge clk);
    access(1'b0, 1'b1, 32'd1024, 32'h0BADC0DE, lows2, wel2, oeh2);
    chk("b2b_total_low",  lows + lows2, 32'd10);
    chk("b2b_store_low",  lows2, 32'd5);
    mem_w_en = 1'b0;
    chk("b2b_store_lo",   {16'd0, sram_mem[0]}, 32'h0000C0DE);
    chk("b2b_store_hi",   {16'd0, sram_mem[1]}, 32'h00000BAD);
    chk("b2b_read_held",  read_data, 32'hCAFEF00D);
    @(negedge clk);

    // Both enables set: behaves as a store
    access(1'b1, 1'b1, 32'd1032, 32'h12345678, lows, wel, oeh);
    chk("both_ready_low", lows, 32'd5);
    chk("both_we_low",    wel,  32'd2);
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    chk("both_lo_half",   {16'd0, sram_mem[4]}, 32'h00005678);
    chk("both_hi_half",   {16'd0, sram_mem[5]}, 32'h00001234);
    chk("both_read_held", read_data, 32'hCAFEF00D);
    @(negedge clk);

    access(1'b1, 1'b0, 32'd1032, 32'd0, lows, wel, oeh);
    mem_r_en = 1'b0;
    chk("reload_data", read_data, 32'h12345678);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
